// File: rtl/muldiv_pkg.sv
// Shared op/state types and op-decode helpers for the multiply/divide HI/LO unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } md_state_t;

  function automatic logic is_div(input md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed(input md_op_t op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_acc(input md_op_t op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_sub(input md_op_t op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes: load latches operands, each step retires one
// quotient bit; `last` flags the WIDTH-th step, after which quo/rem hold the final result.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             last
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   partial, diff;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    partial = {rem_q, quo_q[WIDTH-1]};
    diff    = partial - {1'b0, dvs_q};
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      // A borrow out of the trial subtract means the divisor did not fit: keep the partial.
      rem_d = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quo  = quo_q;
  assign rem  = rem_q;
  assign last = step && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative mul/div engine with HI/LO: mul done MUL_CYCLES after accept, div done WIDTH+2 after.
// Stalls EX only while busy and a request, HI/LO read or HI/LO write is presented; cancel aborts.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  md_op_t             op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               hilo_rd,
  output logic               stall,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] hilo
);
  localparam int PIPE_DEPTH = (MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 1;
  localparam int MCW        = $clog2(MUL_CYCLES + 1);
  localparam logic [MCW-1:0] MUL_CNT_INIT = (MUL_CYCLES > 1) ? MCW'(MUL_CYCLES - 2) : '0;

  md_state_t          state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d, bz_q, bz_d;
  logic [MCW-1:0]     mul_cnt_q, mul_cnt_d;
  logic [2*WIDTH-1:0] mul_pipe_q [PIPE_DEPTH];
  logic [2*WIDTH-1:0] mul_pipe_d [PIPE_DEPTH];
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, quo_fix, rem_fix;
  logic               op_signed, div_load, div_step, div_last;

  assign op_signed = is_signed(op);
  assign a_ext     = op_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign b_ext     = op_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  // The low 2*WIDTH bits of the extended product are exact for both signednesses.
  assign prod      = a_ext * b_ext;
  assign mul_res   = !is_acc(op) ? prod :
                     is_sub(op)  ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod;
  assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
  assign quo_fix   = qneg_q ? -quo : quo;
  assign rem_fix   = rneg_q ? -rem : rem;

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo      (quo),
    .rem      (rem),
    .last     (div_last)
  );

  always_comb begin
    mul_pipe_d[0] = mul_res;
    for (int i = 1; i < PIPE_DEPTH; i++) mul_pipe_d[i] = mul_pipe_q[i-1];
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    bz_d      = bz_q;
    mul_cnt_d = mul_cnt_q;
    div_load  = 1'b0;
    div_step  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !cancel) begin
          if (is_div(op)) begin
            state_d  = ST_DIV;
            busy_d   = 1'b1;
            div_load = 1'b1;
            a_d      = a;
            bz_d     = (b == '0);
            qneg_d   = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d   = op_signed && a[WIDTH-1];
          end else if (MUL_CYCLES == 1) begin
            state_d        = ST_DONE;
            done_d         = 1'b1;
            {hi_d, lo_d}   = mul_res;
          end else begin
            state_d   = ST_MUL;
            busy_d    = 1'b1;
            mul_cnt_d = MUL_CNT_INIT;
          end
        end
      end
      ST_MUL: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (mul_cnt_q == '0) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          {hi_d, lo_d} = mul_pipe_q[PIPE_DEPTH-1];
        end else begin
          mul_cnt_d = mul_cnt_q - MCW'(1);
          busy_d    = 1'b1;
        end
      end
      ST_DIV: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          busy_d   = 1'b1;
          div_step = 1'b1;
          if (div_last) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (bz_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      bz_q      <= 1'b0;
      mul_cnt_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) mul_pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      bz_q      <= bz_d;
      mul_cnt_q <= mul_cnt_d;
      for (int i = 0; i < PIPE_DEPTH; i++) mul_pipe_q[i] <= mul_pipe_d[i];
    end
  end

  assign stall = busy_q & (start | hilo_rd | hi_we | lo_we);
  assign busy  = busy_q;
  assign done  = done_q;
  assign hilo  = {hi_q, lo_q};

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Bench for muldiv_hilo_unit: directed vector table, random ops against an arithmetic model,
// and hand sequences for stall, cancel and asynchronous reset.
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  localparam int W       = 32;
  localparam int MC      = 2;
  localparam int DIV_LAT = W + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  md_op_t        op;
  logic [W-1:0]  a, b, wdata;
  logic          cancel, hi_we, lo_we, hilo_rd;
  logic          stall, busy, done;
  logic [2*W-1:0] hilo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_hilo_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hilo_rd(hilo_rd),
    .stall(stall), .busy(busy), .done(done), .hilo(hilo)
  );

  typedef struct {
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic        preset;
    logic [63:0] pre;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hilo(input logic [63:0] v);
    hi_we = 1'b1; wdata = v[63:32];
    tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = v[31:0];
    tick();
    lo_we = 1'b0;
  endtask

  // Latency counts cycles after the accept edge up to and including the done cycle.
  task automatic run_op(input md_op_t o, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] res, output int lat);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    res = hilo;
  endtask

  function automatic logic [63:0] ref_model(input md_op_t o, input logic [31:0] x,
                                            input logic [31:0] y, input logic [63:0] hl);
    longint unsigned ux = 64'(x);
    longint unsigned uy = 64'(y);
    logic [63:0]     p;
    int              qs, rs;
    if (is_signed(o)) p = 64'(longint'($signed(x)) * longint'($signed(y)));
    else              p = 64'(ux * uy);
    case (o)
      OP_MULT, OP_MULTU: return p;
      OP_MADD, OP_MADDU: return hl + p;
      OP_MSUB, OP_MSUBU: return hl - p;
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qs = $signed(x) / $signed(y);
        rs = $signed(x) % $signed(y);
        return {rs, qs};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res, hl_ref, exp, h_saved;
    int          lat, n_stall, cyc;
    logic        saw_done;
    md_op_t      o;
    logic [31:0] x, y;

    rst = 1'b0; start = 1'b0; op = OP_MULT; a = '0; b = '0; cancel = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; hilo_rd = 1'b0;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFA, MC};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,        1'b0, 64'd0, 64'h0000_0002_FFFF_FFFA, MC};
    vecs[2] = '{OP_MSUB,  32'd2,         32'd7,        1'b1, 64'h0000_0000_0000_000A, 64'hFFFF_FFFF_FFFF_FFFC, MC};
    vecs[3] = '{OP_MADDU, 32'hFFFF_FFFF, 32'd2,        1'b0, 64'd0, 64'h0000_0001_FFFF_FFFA, MC};
    vecs[4] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT};
    vecs[5] = '{OP_DIV,   32'h0000_007B, 32'd0,        1'b0, 64'd0, 64'h0000_007B_FFFF_FFFF, DIV_LAT};
    vecs[6] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'd0, 64'h0000_0000_8000_0000, DIV_LAT};
    vecs[7] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd10,       1'b0, 64'd0, 64'h0000_0005_1999_9999, DIV_LAT};
    vecs[8] = '{OP_MADD,  32'hFFFF_FFFF, 32'd1,        1'b1, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, MC};
    vecs[9] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 1'b0, 64'd0, 64'h0000_0001_FFFF_FFFD, DIV_LAT};

    #12;
    check("rst_hilo", hilo, 64'd0);
    check("rst_flags", 64'({busy, done, stall}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].preset) begin
        set_hilo(vecs[i].pre);
      end
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_hilo", i), res, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
    end

    hl_ref = {$urandom, $urandom};
    set_hilo(hl_ref);
    check("mt_hilo", hilo, hl_ref);
    for (int i = 0; i < 30; i++) begin
      o = md_op_t'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: y = 32'($urandom_range(1, 9));
        2: begin x = 32'h8000_0000; y = '1; end
        default: ;
      endcase
      exp    = ref_model(o, x, y, hl_ref);
      hl_ref = exp;
      run_op(o, x, y, res, lat);
      check($sformatf("rand%0d_hilo", i), res, exp);
      check($sformatf("rand%0d_lat", i), 64'(lat), 64'(is_div(o) ? DIV_LAT : MC));
    end

    // HI/LO read held across a divide: stalls every busy cycle, never outside busy.
    op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1; hilo_rd = 1'b1;
    #1;
    check("stall_idle", 64'(stall), 64'd0);
    tick();
    start = 1'b0;
    n_stall = 0;
    cyc = 0;
    while (!done && cyc < 200) begin
      if (stall) n_stall++;
      tick();
      cyc++;
    end
    check("stall_busy_cycles", 64'(n_stall), 64'(DIV_LAT - 1));
    check("stall_done_cycle", 64'(stall), 64'd0);
    check("stall_div_hilo", hilo, {32'd2, 32'd14});
    hilo_rd = 1'b0;

    // Cancel in the last busy cycle of a divide.
    h_saved = 64'h1234_5678_9ABC_DEF0;
    set_hilo(h_saved);
    op = OP_DIV; a = 32'd50; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (DIV_LAT - 2) tick();
    check("cancel_busy_before", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("cancel_no_done", 64'(saw_done), 64'd0);
    check("cancel_hilo", hilo, h_saved);
    check("cancel_not_busy", 64'(busy), 64'd0);

    // Start together with cancel in IDLE is dropped.
    op = OP_MULT; a = 32'd3; b = 32'd4; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("startcancel_busy", 64'(busy), 64'd0);
    saw_done = 1'b0;
    repeat (5) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("startcancel_no_done", 64'(saw_done), 64'd0);
    check("startcancel_hilo", hilo, h_saved);

    // Asynchronous reset in the middle of a divide.
    op = OP_DIV; a = 32'd1000; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b0;
    #1;
    check("midrst_flags", 64'({busy, done}), 64'd0);
    check("midrst_hilo", hilo, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    run_op(OP_MULT, 32'd5, 32'd6, res, lat);
    check("postrst_hilo", res, 64'd30);
    check("postrst_lat", 64'(lat), 64'(MC));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
